bin_to_gray_tx: RTL and testbench



---
 rtl/gray_pkg.sv | 12 +
 rtl/sync_edge_det.sv | 31 +++
 rtl/bin_to_gray_tx.sv | 115 +++++++++++
 tb/tb_bin_to_gray_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code width, type and conversion helper
package gray_pkg;

    localparam int GRAY_W = 4;

    typedef logic [GRAY_W-1:0] gray_t;

    function automatic gray_t bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer with rising-edge detector
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic evt
);

    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // History is cleared by reset, so a level held high through reset
    // release shows up as exactly one rising edge afterwards.
    assign level = s2;
    assign evt   = s2 & ~s2_d;

endmodule

// File: rtl/bin_to_gray_tx.sv
// rtl/bin_to_gray_tx.sv - switch/button driven binary counter with registered Gray output
module bin_to_gray_tx
    import gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         read,
    input  logic [W-1:0] inSwitch,
    input  logic         step,
    input  logic         up_dn,
    output logic [W-1:0] bin_out,
    output logic [W-1:0] gray_out,
    output logic         gray_valid
);

    logic         read_lvl;
    logic         read_evt;
    logic         step_lvl;
    logic         step_evt;

    logic [W-1:0] sw_s1;
    logic [W-1:0] sw_s2;
    logic         ud_s1;
    logic         ud_s2;

    logic [W-1:0] bin_q;
    logic [W-1:0] bin_next;
    logic         any_evt;
    logic         upd_q;
    logic [W-1:0] gray_q;
    logic [W-1:0] gray_next;
    logic         valid_q;

    sync_edge_det u_read_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (read),
        .level    (read_lvl),
        .evt      (read_evt)
    );

    sync_edge_det u_step_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (step),
        .level    (step_lvl),
        .evt      (step_evt)
    );

    // Only the edge events drive this block; the levels are not needed.
    logic unused_lvl;
    assign unused_lvl = read_lvl ^ step_lvl;

    // Load has priority; a step event in the same cycle is dropped.
    always_comb begin
        bin_next = bin_q;
        any_evt  = 1'b0;
        if (read_evt) begin
            bin_next = sw_s2;
            any_evt  = 1'b1;
        end else if (step_evt) begin
            any_evt = 1'b1;
            if (ud_s2) begin
                bin_next = bin_q + W'(1);
            end else begin
                bin_next = bin_q - W'(1);
            end
        end
    end

    generate
        if (W == GRAY_W) begin : g_pkg_conv
            gray_t gray_pkg_val;
            assign gray_pkg_val = bin2gray(bin_q);
            assign gray_next    = gray_pkg_val;
        end else begin : g_gen_conv
            assign gray_next = bin_q ^ (bin_q >> 1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            ud_s1   <= 1'b0;
            ud_s2   <= 1'b0;
            bin_q   <= '0;
            upd_q   <= 1'b0;
            gray_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sw_s1 <= inSwitch;
            sw_s2 <= sw_s1;
            ud_s1 <= up_dn;
            ud_s2 <= ud_s1;
            if (any_evt) begin
                bin_q <= bin_next;
            end
            // Gray register follows the counter one cycle later, and only
            // when an event landed, so it never moves between events.
            upd_q   <= any_evt;
            valid_q <= upd_q;
            if (upd_q) begin
                gray_q <= gray_next;
            end
        end
    end

    assign bin_out    = bin_q;
    assign gray_out   = gray_q;
    assign gray_valid = valid_q;

endmodule

// File: tb/tb_bin_to_gray_tx.sv
// tb/tb_bin_to_gray_tx.sv - directed table-driven bench for bin_to_gray_tx
`timescale 1ns/1ps
module tb_bin_to_gray_tx;

    logic       clk;
    logic       rst;
    logic       read;
    logic [3:0] inSwitch;
    logic       step;
    logic       up_dn;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic       gray_valid;

    int total = 0;
    int bad   = 0;
    logic [3:0] cur_gray;

    typedef struct {
        logic       rd;
        logic       st;
        logic       ud;
        logic [3:0] sw;
        logic [3:0] eb;
        logic [3:0] eg;
        logic       onebit;
    } vec_t;

    vec_t vecs[10];

    bin_to_gray_tx #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .read       (read),
        .inSwitch   (inSwitch),
        .step       (step),
        .up_dn      (up_dn),
        .bin_out    (bin_out),
        .gray_out   (gray_out),
        .gray_valid (gray_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_event(input logic rd, input logic st, input logic ud,
                             input logic [3:0] sw, input logic [3:0] eb,
                             input logic [3:0] eg, input logic onebit, input string tag);
        int pulses;
        pulses = 0;
        inSwitch = sw;
        up_dn    = ud;
        repeat (3) @(negedge clk);
        read = rd;
        step = st;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                read = 1'b0;
                step = 1'b0;
            end
            if (gray_valid) pulses++;
            if (i == 3) begin
                check({tag, " bin"}, bin_out, eb);
                check({tag, " gray_hold"}, gray_out, cur_gray);
                check({tag, " valid_early"}, gray_valid, 1'b0);
            end
            if (i == 4) begin
                check({tag, " valid"}, gray_valid, 1'b1);
                check({tag, " gray"}, gray_out, eg);
                if (onebit) check({tag, " one_bit_flip"}, $countones(gray_out ^ cur_gray), 1);
            end
        end
        check({tag, " pulses"}, pulses, 1);
        cur_gray = eg;
    endtask

    initial begin
        int pulses;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 4'b1011, 4'b1011, 4'b1110, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 4'b1110, 4'b1110, 4'b1001, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 4'b1000, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1110, 4'b1001, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 4'b0101, 4'b0101, 4'b0111, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101, 4'b0111, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1};

        rst      = 1'b1;
        read     = 1'b1;
        step     = 1'b1;
        up_dn    = 1'b1;
        inSwitch = 4'b0011;

        // reset with both buttons held: one load after release
        repeat (2) @(negedge clk);
        check("reset bin", bin_out, 4'b0000);
        check("reset gray", gray_out, 4'b0000);
        check("reset valid", gray_valid, 1'b0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (gray_valid) pulses++;
            if (i == 4) begin
                check("post_reset valid", gray_valid, 1'b1);
                check("post_reset gray", gray_out, 4'b0010);
                check("post_reset bin", bin_out, 4'b0011);
            end
        end
        check("post_reset pulses", pulses, 1);
        read = 1'b0;
        step = 1'b0;
        cur_gray = 4'b0010;

        for (int v = 0; v < 10; v++) begin
            run_event(vecs[v].rd, vecs[v].st, vecs[v].ud, vecs[v].sw,
                      vecs[v].eb, vecs[v].eg, vecs[v].onebit, $sformatf("vec%0d", v));
        end

        // down wrap straight out of reset
        @(negedge clk);
        rst   = 1'b1;
        up_dn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst2 bin", bin_out, 4'b0000);
        cur_gray = 4'b0000;
        run_event(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1, "down_wrap");

        // reset lands while a step edge is in the synchronizer
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (gray_valid) pulses++;
        end
        check("midflight pulses", pulses, 0);
        check("midflight bin", bin_out, 4'b0000);
        check("midflight gray", gray_out, 4'b0000);

        // back-to-back: load then step on consecutive event cycles
        inSwitch = 4'b0110;
        up_dn    = 1'b1;
        repeat (3) @(negedge clk);
        read = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) step = 1'b1;
            if (i == 2) begin
                read = 1'b0;
                step = 1'b0;
            end
            if (i == 4) begin
                check("b2b valid1", gray_valid, 1'b1);
                check("b2b gray1", gray_out, 4'b0101);
            end
            if (i == 5) begin
                check("b2b valid2", gray_valid, 1'b1);
                check("b2b gray2", gray_out, 4'b0100);
                check("b2b bin", bin_out, 4'b0111);
            end
            if (i == 6) check("b2b valid_end", gray_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
